// File: rtl/stack_drain_ctrl.sv
// Read-side controller for a LIFO stack. On start it pops words one at a time and
// hands each one to a downstream consumer over a valid/ready stream. The drain ends
// when the stack runs empty, when the word limit is reached, or after an abort.
module stack_drain_ctrl #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  max_count,
  input  logic                  stk_empty,
  input  logic [DATA_WIDTH-1:0] stk_data,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  drained_cnt,
  output logic                  error
);

  typedef enum logic [2:0] {StIdle, StPop, StWait, StPresent, StDone} state_e;

  // Latency counter covers RD_LATENCY up to 7.
  localparam logic [2:0] LatLoad = 3'(RD_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(STACK_DEPTH);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  limit_q, limit_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [2:0]            lat_q, lat_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  pop_q, busy_q, done_q;

  // Handshake count saturates at the stack depth rather than wrapping.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  // Next-state, counters and stream data.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    abort_d = abort_q;
    err_d   = err_q;
    data_d  = data_q;
    valid_d = valid_q;

    case (state_q)
      StIdle: begin
        // start beats a same-cycle abort: abort is simply not looked at here.
        if (start) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          if (stk_empty) begin
            state_d = StDone;
          end else begin
            limit_d = max_count;
            state_d = StPop;
          end
        end
      end
      StPop: begin
        lat_d   = LatLoad;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == 3'd0) begin
          data_d  = stk_data;
          valid_d = 1'b1;
          state_d = StPresent;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StPresent: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_inc;
          // An abort arriving in the handshake cycle itself also ends the drain.
          if (((limit_q != '0) && (cnt_inc == limit_q)) || stk_empty || abort_q || abort) begin
            state_d = StDone;
          end else begin
            state_d = StPop;
          end
        end
      end
      StDone: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q inside {StPop, StWait, StPresent})) begin
      abort_d = 1'b1;
    end
    if (start && (state_q != StIdle)) begin
      err_d = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      limit_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pop_q   <= (state_d == StPop);
      busy_q  <= (state_d inside {StPop, StWait, StPresent});
      done_q  <= (state_d == StDone);
    end
  end

  assign stk_pop     = pop_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign drained_cnt = cnt_q;
  assign error       = err_q;

endmodule
